// File: rtl/z80_dma_arbiter.sv
// z80_dma_arbiter
// Block-copy DMA engine that borrows the memory bus from a Z80-style CPU.
// A start pulse in IDLE latches a source address, a destination address and
// a byte count. The engine requests the bus, copies one byte every three
// cycles (RD, RDW, WR) and hands the bus back after every BURST bytes.
// BURST = 0 keeps the bus until the whole block has been copied.
//
// Bus handshake: o_busrq_n is held low from REQ through the last WR of a
// tenure. The engine starts moving data only after it samples i_busak_n low.
// It then ignores i_busak_n until it has raised o_busrq_n again in REL.
// REL waits for i_busak_n to be sampled high before the next request or the
// done pulse.
//
// Ports
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_start                one-cycle copy request (sampled only in IDLE)
//   i_src, i_dst, i_len    copy parameters, latched on an accepted start
//   o_busrq_n, i_busak_n   bus request / acknowledge to the CPU (active-low)
//   o_dma_en               engine owns the memory bus
//   o_dma_a, o_dma_do      memory address and write data (0 when not owning)
//   o_dma_we               one-cycle write strobe per byte
//   i_mem_di               read data, valid one cycle after the address
//   o_busy, o_done         busy from accepted start through done; done pulse
//   o_state                current FSM state (debug)
module z80_dma_arbiter #(
    parameter int BURST = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_src,
    input  logic [15:0] i_dst,
    input  logic [15:0] i_len,
    output logic        o_busrq_n,
    input  logic        i_busak_n,
    output logic        o_dma_en,
    output logic [15:0] o_dma_a,
    output logic [7:0]  o_dma_do,
    output logic        o_dma_we,
    input  logic [7:0]  i_mem_di,
    output logic        o_busy,
    output logic        o_done,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_RDW  = 3'd3,
        S_WR   = 3'd4,
        S_REL  = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    localparam logic [15:0] BURST_W = 16'(BURST);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic [15:0] r_rem;
    logic [15:0] r_tenure;
    logic [7:0]  r_data;

    logic [15:0] w_rem_dec;
    logic [15:0] w_ten_inc;
    logic        w_burst_hit;

    assign w_rem_dec   = r_rem - 16'd1;
    assign w_ten_inc   = r_tenure + 16'd1;
    // Yield the bus once this tenure has moved BURST bytes.
    assign w_burst_hit = (BURST != 0) && (w_ten_inc == BURST_W);
    assign o_state     = r_state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        o_busrq_n = 1'b1;
        o_dma_en  = 1'b0;
        o_dma_a   = 16'h0000;
        o_dma_do  = 8'h00;
        o_dma_we  = 1'b0;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    // A zero-length copy completes without touching the bus.
                    w_next = (i_len != 16'h0000) ? S_REQ : S_FIN;
                end
            end
            S_REQ: begin
                o_busrq_n = 1'b0;
                if (!i_busak_n) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                o_busrq_n = 1'b0;
                o_dma_en  = 1'b1;
                o_dma_a   = r_src;
                w_next    = S_RDW;
            end
            S_RDW: begin
                o_busrq_n = 1'b0;
                o_dma_en  = 1'b1;
                o_dma_a   = r_src;
                w_next    = S_WR;
            end
            S_WR: begin
                o_busrq_n = 1'b0;
                o_dma_en  = 1'b1;
                o_dma_a   = r_dst;
                o_dma_do  = r_data;
                o_dma_we  = 1'b1;
                if (w_rem_dec == 16'h0000 || w_burst_hit) begin
                    w_next = S_REL;
                end else begin
                    w_next = S_RD;
                end
            end
            S_REL: begin
                // r_rem == 0 distinguishes the final release from a yield.
                if (i_busak_n) begin
                    w_next = (r_rem == 16'h0000) ? S_FIN : S_REQ;
                end
            end
            S_FIN: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_src    <= 16'h0000;
            r_dst    <= 16'h0000;
            r_rem    <= 16'h0000;
            r_tenure <= 16'h0000;
            r_data   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && i_len != 16'h0000) begin
                        r_src    <= i_src;
                        r_dst    <= i_dst;
                        r_rem    <= i_len;
                        r_tenure <= 16'h0000;
                    end
                end
                S_RDW: begin
                    r_data <= i_mem_di;
                end
                S_WR: begin
                    // Counters wrap naturally at 0xFFFF.
                    r_src    <= r_src + 16'd1;
                    r_dst    <= r_dst + 16'd1;
                    r_rem    <= w_rem_dec;
                    r_tenure <= w_ten_inc;
                end
                S_REL: begin
                    if (i_busak_n && r_rem != 16'h0000) begin
                        r_tenure <= 16'h0000;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
